err_stats_collector: RTL and testbench

- Hardware consumer of the adder-evaluation record stream: each record is one (approximate sum, exact sum) pair from a functional unit under test and its exact reference adder.
- Computes absolute error per record and accumulates run statistics: sample count, erroneous-sample count, max AE, sum of AE, sum of squared AE.
- Replaces host-side post-processing of the result file.
- Sits between the DUT/reference-adder pair and the on-chip debug/readout logic.

---
 rtl/err_stats_pkg.sv | 45 ++++
 rtl/err_abs_sq.sv | 53 +++++
 rtl/err_stats_collector.sv | 134 +++++++++++++
 tb/tb_err_stats_collector.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/err_stats_pkg.sv
// err_stats_pkg: shared types, default widths and saturating add
// for the adder-evaluation error statistics collector.
package err_stats_pkg;

  localparam int W_DEF     = 32;
  localparam int CNT_W_DEF = 32;
  localparam int SAE_W_DEF = 64;
  localparam int SSE_W_DEF = 100;

  // Working width for saturating arithmetic; every accumulator
  // and its addend must fit below this.
  localparam int ACC_W = 128;

  typedef logic [ACC_W-1:0] acc_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic sat;
    acc_t val;
  } sat_t;

  // a + b clamped to the all-ones value of a w-bit register.
  function automatic sat_t sat_add(
    input acc_t a,
    input acc_t b,
    input int   w
  );
    acc_t lim;
    acc_t sum;
    sat_t r;
    if (w >= ACC_W) lim = '1;
    else lim = (acc_t'(1) << w) - acc_t'(1);
    sum   = a + b;
    r.sat = (sum > lim) || (sum < a);
    r.val = r.sat ? lim : sum;
    return r;
  endfunction

endpackage

// File: rtl/err_abs_sq.sv
// err_abs_sq: two-stage pipe, S1 signed difference, S2 |d| and |d|^2.
// Ports: Clk, Rst, in_valid/a/b in; s1_valid, out_valid, ae, sq out.
module err_abs_sq
  import err_stats_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic           in_valid,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           s1_valid,
  output logic           out_valid,
  output logic [W:0]     ae,
  output logic [2*W+1:0] sq
);

  logic [W:0]     d_q;
  logic [W:0]     ae1;
  logic [2*W+1:0] ae1_x;

  // d_q holds a W+1 bit two's complement difference; negating
  // it in W+1 bits is exact for every reachable value.
  assign ae1   = d_q[W] ? (~d_q + 1'b1) : d_q;
  assign ae1_x = {{(W+1){1'b0}}, ae1};

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      s1_valid <= 1'b0;
      d_q      <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid)
        d_q <= {a[W-1], a} - {b[W-1], b};
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      out_valid <= 1'b0;
      ae        <= '0;
      sq        <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        ae <= ae1;
        sq <= ae1_x * ae1_x;
      end
    end
  end

endmodule

// File: rtl/err_stats_collector.sv
// err_stats_collector: per-run AE statistics over an (approx, exact) stream.
// Ports: in_* record handshake, stats_* readout/ack, saturating stats, ovf.
module err_stats_collector
  import err_stats_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int SAE_W = SAE_W_DEF,
  parameter int SSE_W = SSE_W_DEF
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [W-1:0]     in_approx,
  input  logic [W-1:0]     in_exact,
  output logic             stats_valid,
  input  logic             stats_ack,
  output logic [CNT_W-1:0] n_samples,
  output logic [CNT_W-1:0] n_errors,
  output logic [W:0]       max_ae,
  output logic [SAE_W-1:0] sum_ae,
  output logic [SSE_W-1:0] sum_se,
  output logic             ovf
);

  state_t state;
  state_t state_n;

  logic           xfer;
  logic           clr;
  logic           s1_v;
  logic           s2_v;
  logic [W:0]     ae;
  logic [2*W+1:0] sq;

  sat_t r_n;
  sat_t r_e;
  sat_t r_sae;
  sat_t r_sse;

  // Ready is a function of state only, forced low during reset.
  assign in_ready = ~Rst &
    ((state == IDLE) | (state == ACCUM));
  assign stats_valid = (state == DONE);
  assign xfer = in_valid & in_ready;

  err_abs_sq #(
    .W(W)
  ) u_pipe (
    .Clk       (Clk),
    .Rst       (Rst),
    .in_valid  (xfer),
    .a         (in_approx),
    .b         (in_exact),
    .s1_valid  (s1_v),
    .out_valid (s2_v),
    .ae        (ae),
    .sq        (sq)
  );

  always_comb begin
    state_n = state;
    clr     = 1'b0;
    unique case (state)
      IDLE, ACCUM: begin
        if (xfer)
          state_n = in_last ? DRAIN : ACCUM;
      end
      DRAIN: begin
        if (!s1_v && !s2_v)
          state_n = DONE;
      end
      DONE: begin
        if (stats_ack) begin
          state_n = IDLE;
          clr     = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    r_n = sat_add(acc_t'(n_samples),
                  acc_t'(1), CNT_W);
    r_e = sat_add(acc_t'(n_errors),
                  acc_t'(ae != '0), CNT_W);
    r_sae = sat_add(acc_t'(sum_ae),
                    acc_t'(ae), SAE_W);
    r_sse = sat_add(acc_t'(sum_se),
                    acc_t'(sq), SSE_W);
  end

  // Clamped results never exceed the register width.
  logic unused_hi;
  assign unused_hi = ^{r_n.val[ACC_W-1:CNT_W],
                       r_e.val[ACC_W-1:CNT_W],
                       r_sae.val[ACC_W-1:SAE_W],
                       r_sse.val[ACC_W-1:SSE_W]};

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= IDLE;
      n_samples <= '0;
      n_errors  <= '0;
      max_ae    <= '0;
      sum_ae    <= '0;
      sum_se    <= '0;
      ovf       <= 1'b0;
    end else begin
      state <= state_n;
      if (clr) begin
        n_samples <= '0;
        n_errors  <= '0;
        max_ae    <= '0;
        sum_ae    <= '0;
        sum_se    <= '0;
        ovf       <= 1'b0;
      end else if (s2_v) begin
        n_samples <= r_n.val[CNT_W-1:0];
        n_errors  <= r_e.val[CNT_W-1:0];
        sum_ae    <= r_sae.val[SAE_W-1:0];
        sum_se    <= r_sse.val[SSE_W-1:0];
        if (ae > max_ae)
          max_ae <= ae;
        ovf <= ovf | r_n.sat | r_e.sat |
               r_sae.sat | r_sse.sat;
      end
    end
  end

endmodule

// File: tb/tb_err_stats_collector.sv
// tb_err_stats_collector: randomized + directed bench with a
// run-total reference model; checks two DUTs (default, SAE_W=8).
module tb_err_stats_collector;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        in_valid;
  logic        in_last;
  logic [31:0] in_approx;
  logic [31:0] in_exact;
  logic        stats_ack;

  logic        in_ready, stats_valid, ovf;
  logic [31:0] n_samples, n_errors;
  logic [32:0] max_ae;
  logic [63:0] sum_ae;
  logic [99:0] sum_se;

  logic        in_ready_8, stats_valid_8, ovf_8;
  logic [31:0] n_samples_8, n_errors_8;
  logic [32:0] max_ae_8;
  logic [7:0]  sum_ae_8;
  logic [99:0] sum_se_8;

  always #5 Clk = ~Clk;

  err_stats_collector dut (
    .Clk(Clk), .Rst(Rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last),
    .in_approx(in_approx), .in_exact(in_exact),
    .stats_valid(stats_valid), .stats_ack(stats_ack),
    .n_samples(n_samples), .n_errors(n_errors),
    .max_ae(max_ae), .sum_ae(sum_ae),
    .sum_se(sum_se), .ovf(ovf)
  );

  err_stats_collector #(.SAE_W(8)) dut8 (
    .Clk(Clk), .Rst(Rst),
    .in_valid(in_valid), .in_ready(in_ready_8),
    .in_last(in_last),
    .in_approx(in_approx), .in_exact(in_exact),
    .stats_valid(stats_valid_8), .stats_ack(stats_ack),
    .n_samples(n_samples_8), .n_errors(n_errors_8),
    .max_ae(max_ae_8), .sum_ae(sum_ae_8),
    .sum_se(sum_se_8), .ovf(ovf_8)
  );

  int errors = 0;
  int checks = 0;

  // Model: run-level phase plus exact (unsaturated) run totals.
  bit           accepting;
  int           drain_left;
  logic [127:0] t_n, t_e, t_max, t_sae, t_sse;

  function automatic logic [127:0] lim(int w);
    return (128'(1) << w) - 128'(1);
  endfunction

  function automatic logic [127:0] satv(
    logic [127:0] t, int w);
    return (t > lim(w)) ? lim(w) : t;
  endfunction

  task automatic chk(string name,
                     logic [127:0] act,
                     logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic model_clear();
    t_n = 0; t_e = 0; t_max = 0;
    t_sae = 0; t_sse = 0;
  endtask

  task automatic model_add(logic [31:0] a,
                           logic [31:0] e);
    longint d;
    longint mag;
    logic [127:0] m;
    d   = longint'($signed(a)) - longint'($signed(e));
    mag = (d < 0) ? -d : d;
    m   = 128'(mag);
    t_n   = t_n + 1;
    t_e   = t_e + ((mag != 0) ? 1 : 0);
    t_max = (m > t_max) ? m : t_max;
    t_sae = t_sae + m;
    t_sse = t_sse + m * m;
  endtask

  task automatic compare();
    bit done;
    bit ov, ov8;
    done = !accepting && (drain_left == 0);
    chk("in_ready", in_ready, accepting);
    chk("in_ready_8", in_ready_8, accepting);
    chk("stats_valid", stats_valid, done);
    chk("stats_valid_8", stats_valid_8, done);
    if (done) begin
      ov = (t_n > lim(32)) || (t_e > lim(32)) ||
           (t_sae > lim(64)) || (t_sse > lim(100));
      ov8 = (t_n > lim(32)) || (t_e > lim(32)) ||
            (t_sae > lim(8)) || (t_sse > lim(100));
      chk("n_samples", n_samples, satv(t_n, 32));
      chk("n_errors", n_errors, satv(t_e, 32));
      chk("max_ae", max_ae, t_max);
      chk("sum_ae", sum_ae, satv(t_sae, 64));
      chk("sum_se", sum_se, satv(t_sse, 100));
      chk("ovf", ovf, ov);
      chk("n_samples_8", n_samples_8, satv(t_n, 32));
      chk("sum_ae_8", sum_ae_8, satv(t_sae, 8));
      chk("sum_se_8", sum_se_8, satv(t_sse, 100));
      chk("ovf_8", ovf_8, ov8);
    end
  endtask

  // One clock: drive at negedge, check, then advance the model
  // with what the edge will see.
  task automatic step(bit v, bit last,
                      logic [31:0] a, logic [31:0] e,
                      bit ack);
    bit xfer;
    bit done;
    in_valid  = v;
    in_last   = last;
    in_approx = a;
    in_exact  = e;
    stats_ack = ack;
    #1 compare();
    @(posedge Clk);
    done = !accepting && (drain_left == 0);
    xfer = v && accepting;
    if (xfer) begin
      model_add(a, e);
      if (last) begin
        accepting  = 0;
        drain_left = 3;
      end
    end else if (!accepting && drain_left > 0) begin
      drain_left--;
    end else if (done && ack) begin
      model_clear();
      accepting = 1;
    end
    @(negedge Clk);
  endtask

  task automatic idle(int k);
    for (int i = 0; i < k; i++)
      step(0, 0, 32'h0, 32'h0, 0);
  endtask

  task automatic ack();
    step(0, 0, 32'h0, 32'h0, 1);
  endtask

  task automatic reset_checks(string tag);
    chk({tag, "_ready"}, in_ready, 0);
    chk({tag, "_valid"}, stats_valid, 0);
    chk({tag, "_n"}, n_samples, 0);
    chk({tag, "_e"}, n_errors, 0);
    chk({tag, "_max"}, max_ae, 0);
    chk({tag, "_sae"}, sum_ae, 0);
    chk({tag, "_sse"}, sum_se, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_ovf8"}, ovf_8, 0);
  endtask

  task automatic apply_reset(string tag);
    Rst = 1'b1;
    in_valid = 0; in_last = 0; stats_ack = 0;
    #1 reset_checks(tag);
    accepting  = 1;
    drain_left = 0;
    model_clear();
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, e;
    int len;
    in_approx = 0; in_exact = 0;
    apply_reset("por");

    // single exact record
    step(1, 1, 32'd5, 32'd5, 0);
    idle(3);
    chk("t1_valid", stats_valid, 1);
    chk("t1_n", n_samples, 1);
    chk("t1_e", n_errors, 0);
    chk("t1_max", max_ae, 0);
    chk("t1_sae", sum_ae, 0);
    chk("t1_sse", sum_se, 0);
    ack();

    // three back-to-back records
    step(1, 0, 32'd10, 32'd7, 0);
    step(1, 0, 32'hFFFF_FFFC, 32'd4, 0);
    step(1, 1, 32'd100, 32'd100, 0);
    idle(3);
    chk("t2_n", n_samples, 3);
    chk("t2_e", n_errors, 2);
    chk("t2_max", max_ae, 8);
    chk("t2_sae", sum_ae, 11);
    chk("t2_sse", sum_se, 73);
    ack();

    // extreme difference
    step(1, 1, 32'h7FFF_FFFF, 32'h8000_0000, 0);
    idle(3);
    chk("t3_max", max_ae, 33'h0_FFFF_FFFF);
    chk("t3_sse", sum_se, 100'hFFFF_FFFE_0000_0001);
    chk("t3_ovf", ovf, 0);
    chk("t3_ovf8", ovf_8, 1);
    ack();

    // 8-bit sum_ae saturation
    step(1, 0, 32'd200, 32'd0, 0);
    step(1, 1, 32'd200, 32'd0, 0);
    idle(3);
    chk("t4_sae8", sum_ae_8, 255);
    chk("t4_ovf8", ovf_8, 1);
    chk("t4_sae", sum_ae, 400);
    ack();
    idle(1);
    chk("t4_ovf8_clr", ovf_8, 0);
    chk("t4_sae8_clr", sum_ae_8, 0);

    // reset in the middle of a run
    step(1, 0, 32'd9, 32'd1, 0);
    step(1, 0, 32'd9, 32'd1, 1);
    idle(3);
    chk("t5_live_n", n_samples, 2);
    chk("t5_live_sae", sum_ae, 16);
    apply_reset("mid");
    step(1, 1, 32'd3, 32'd0, 0);
    idle(3);
    chk("t5_n", n_samples, 1);
    chk("t5_sae", sum_ae, 3);
    ack();

    // valid held through DONE while acking
    step(1, 1, 32'd1, 32'd2, 0);
    for (int i = 0; i < 3; i++)
      step(1, 0, 32'd50, 32'd0, 0);
    chk("t6_ready_done", in_ready, 0);
    step(1, 0, 32'd50, 32'd0, 1);
    step(1, 1, 32'd7, 32'd7, 0);
    idle(3);
    chk("t6_n", n_samples, 1);
    chk("t6_e", n_errors, 0);
    ack();

    // randomized runs
    for (int r = 0; r < 60; r++) begin
      len = $urandom_range(1, 8);
      for (int k = 0; k < len; k++) begin
        while ($urandom_range(0, 3) == 0)
          step(0, 0, $urandom, $urandom,
               bit'($urandom_range(0, 1)));
        a = $urandom;
        if ($urandom_range(0, 1) == 1)
          e = a + 32'($urandom_range(0, 16)) - 32'd8;
        else
          e = $urandom;
        step(1, k == len - 1, a, e,
             bit'($urandom_range(0, 1)));
      end
      for (int k = $urandom_range(3, 6); k > 0; k--)
        step(bit'($urandom_range(0, 1)), 0,
             $urandom, $urandom, 0);
      step(bit'($urandom_range(0, 1)), 0,
           $urandom, $urandom, 1);
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
